seg7_scan: RTL and testbench

Multiplexed N-digit hexadecimal 7-segment display driver for the npc board-I/O path. It accepts a full display frame (nibble values, decimal points, digit enables) over a valid/ready handshake and holds it in a shadow register. It then time-multiplexes the digits onto one shared active-low segment bus with a programmable scan rate. New frames commit only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg7_scan.sv | 207 ++++++++++++++++++++
 tb/tb_seg7_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed DIGITS-digit hex 7-segment driver with a shadowed frame register.
// Define SEG7_BLINK_EN to add the blink_mask port and the blink frame counter.
module seg7_scan #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_value,
  input  logic [DIGITS-1:0]   in_dp,
  input  logic [DIGITS-1:0]   in_en,
  input  logic                lz_blank,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_done
);

  // state | meaning
  // RUN   | no pending frame, in_ready high
  // PEND  | frame captured, waiting for the frame boundary to commit it
  typedef enum logic {RUN, PEND} state_t;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] act_value_q, act_value_d, pend_value_q, pend_value_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_done_q, frame_done_d;
  logic                boundary;
  logic [DIGITS-1:0]   lz_dark;
  logic [DIGITS-1:0]   blink_dark;
  logic                lz_run;
  logic                blank;
  logic [3:0]          cur_nib;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign boundary = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    state_d      = state_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    in_ready     = (state_q == RUN);
    case (state_q)
      RUN: begin
        if (in_valid) begin
          pend_value_d = in_value;
          pend_dp_d    = in_dp;
          pend_en_d    = in_en;
          state_d      = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          act_value_d = pend_value_q;
          act_dp_d    = pend_dp_q;
          act_en_d    = pend_en_q;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_done_d = boundary;
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (boundary) begin
      if (blink_cnt_q == '0) begin
        blink_cnt_d = BW'(BLINK_FRAMES - 1);
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= BW'(BLINK_FRAMES - 1);
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_dark = blink_on_d ? '0 : blink_mask;
`else
  assign blink_dark = '0;
`endif

  // Outputs are built from next-cycle index/frame so they change together with the index.
  always_comb begin
    lz_dark = '0;
    lz_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run & (act_value_d[4*k +: 4] == 4'h0);
      if (k > 0) lz_dark[k] = lz_blank & lz_run;
    end
    cur_nib = act_value_d[{idx_d, 2'b00} +: 4];
    blank   = ~act_en_d[idx_d] | lz_dark[idx_d] | blink_dark[idx_d];
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    dig_d   = '1;
    if (!blank) begin
      seg_d        = hex_seg(cur_nib);
      dp_d         = ~act_dp_d[idx_d];
      dig_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      dig_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with DIGITS=4, SCAN_DIV=4 (16-cycle frames).
// Expected frames are queued by frame number; the monitor checks each frame slot by slot.
module tb_seg7_scan;
  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int FRAME_CYC = DIGITS * SCAN_DIV;
  localparam logic [27:0] SEG_DARK = {4{7'h7F}};

  logic                clock;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] in_value;
  logic [DIGITS-1:0]   in_dp;
  logic [DIGITS-1:0]   in_en;
  logic                lz_blank;
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0]   blink_mask;
`endif
  logic [6:0]          seg_out;
  logic                dp_out;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame_done;

  seg7_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_dp      (in_dp),
    .in_en      (in_en),
    .lz_blank   (lz_blank),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  typedef struct {
    int          frame;
    logic [27:0] seg;
    logic [15:0] dig;
    logic [3:0]  dp;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic chk_on;
  logic fd_exp;
  int   slot;
  int   cyc;
  int   tests;
  int   fails;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index since reset release; cycle 0 is the one in which reset_n goes high.
  always @(posedge clock) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, want);
    end
  endtask

  task automatic push_exp(input int frame, input logic [27:0] seg, input logic [15:0] dig,
                          input logic [3:0] dp);
    exp_t e;
    e.frame = frame;
    e.seg   = seg;
    e.dig   = dig;
    e.dp    = dp;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc != c && guard < 4000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != c) begin
      tests++;
      fails++;
      $display("FAIL wait_cyc: cycle %0d not reached (at %0d)", c, cyc);
    end
  endtask

  // Beat accepted at the posedge ending cycle c.
  task automatic send(input int c, input logic [15:0] v, input logic [3:0] dp,
                      input logic [3:0] en);
    wait_cyc(c);
    in_value = v;
    in_dp    = dp;
    in_en    = en;
    in_valid = 1'b1;
    chk("send_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      chk_on = 1'b0;
    end else begin
      fd_exp = (cyc >= FRAME_CYC) && (cyc % FRAME_CYC == 0);
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (fd_exp) begin
        chk_on = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].frame < cyc / FRAME_CYC) begin
          tests++;
          fails++;
          $display("FAIL frame_missed: frame %0d was never checked", exp_q[0].frame);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].frame == cyc / FRAME_CYC) begin
          cur    = exp_q.pop_front();
          chk_on = 1'b1;
        end
      end
      if (chk_on) begin
        slot = (cyc % FRAME_CYC) / SCAN_DIV;
        chk("seg_out", 32'(seg_out), 32'(cur.seg[7*slot +: 7]));
        chk("dig_sel", 32'(dig_sel), 32'(cur.dig[4*slot +: 4]));
        chk("dp_out",  32'(dp_out),  32'(cur.dp[slot]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    chk_on   = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    in_dp    = '0;
    in_en    = '0;
    lz_blank = 1'b0;
`ifdef SEG7_BLINK_EN
    blink_mask = '0;
`endif
    reset_n  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_dp", 32'(dp_out), 32'd1);
    chk("rst_dig", 32'(dig_sel), 32'hF);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;

    wait_cyc(1);
    chk("idle_ready", 32'(in_ready), 32'd1);
    push_exp(1, SEG_DARK, 16'hFFFF, 4'hF);

    send(20, 16'h12AF, 4'h0, 4'hF);
    push_exp(2, {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'hF);
    push_exp(3, {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'hF);
    chk("pend_ready", 32'(in_ready), 32'd0);
    in_value = 16'hFFFF;
    in_en    = 4'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pend_ignore_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
    end
    in_valid = 1'b0;

    wait_cyc(47);
    lz_blank = 1'b1;
    send(47, 16'h0040, 4'h0, 4'hF);
    push_exp(4, {7'h7F, 7'h7F, 7'h19, 7'h40}, 16'hFFDE, 4'hF);
    chk("boundary_beat_pending", 32'(in_ready), 32'd0);
    wait_cyc(64);
    chk("commit_ready", 32'(in_ready), 32'd1);

    send(70, 16'h0000, 4'h0, 4'hF);
    push_exp(5, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'hFFFE, 4'hF);
    push_exp(6, {7'h40, 7'h40, 7'h40, 7'h40}, 16'h7BDE, 4'hF);
    wait_cyc(95);
    lz_blank = 1'b0;

    send(98, 16'h3210, 4'b0001, 4'b0101);
    push_exp(7, {7'h7F, 7'h24, 7'h7F, 7'h40}, 16'hFBFE, 4'b1110);

    send(130, 16'h8888, 4'hF, 4'hF);
    wait_cyc(133);
    reset_n = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg_out), 32'h7F);
    chk("midrst_dp", 32'(dp_out), 32'd1);
    chk("midrst_dig", 32'(dig_sel), 32'hF);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
`ifdef SEG7_BLINK_EN
    blink_mask = 4'b1000;
`endif
    reset_n = 1'b1;

    wait_cyc(1);
    chk("postrst_ready", 32'(in_ready), 32'd1);
    push_exp(1, SEG_DARK, 16'hFFFF, 4'hF);
    send(20, 16'h12AF, 4'b0010, 4'hF);
`ifdef SEG7_BLINK_EN
    push_exp(2, {7'h7F, 7'h24, 7'h08, 7'h0E}, 16'hFBDE, 4'b1101);
    push_exp(3, {7'h7F, 7'h24, 7'h08, 7'h0E}, 16'hFBDE, 4'b1101);
`else
    push_exp(2, {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'b1101);
    push_exp(3, {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'b1101);
`endif
    push_exp(4, {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'b1101);
    push_exp(5, {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'b1101);

    wait_cyc(100);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
